password_char_tx: RTL and testbench

// - Serializer at the transmit end of the password character stream. The per-character checkers (vowel, digit, ...) consume this stream.
// - Captures a packed password of up to MAX_LEN ASCII characters on a load pulse.
// - Emits the characters one per accepted transfer over a valid/ready handshake, first character first.
// - Flags the final character and pulses done, so downstream counters and checkers know where the password ends.

---
 rtl/pwd_pkg.sv | 27 ++
 rtl/pwd_shift_reg.sv | 30 +++
 rtl/password_char_tx.sv | 134 +++++++++++++
 tb/tb_password_char_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwd_pkg.sv
// Shared definitions for the password character stream: default sizes,
// ASCII constants used by the per-character checkers, tx state encoding.
package pwd_pkg;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_CHAR_W  = 8;
  localparam int DEF_LEN_W   = 5;

  localparam logic [7:0] CH_A   = 8'h61;
  localparam logic [7:0] CH_E   = 8'h65;
  localparam logic [7:0] CH_I   = 8'h69;
  localparam logic [7:0] CH_O   = 8'h6F;
  localparam logic [7:0] CH_U   = 8'h75;
  localparam logic [7:0] CH_NUL = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_e;

  // Lower-case vowel test shared by the downstream checkers.
  function automatic logic is_vowel(input logic [7:0] c);
    return (c == CH_A) || (c == CH_E) || (c == CH_I) || (c == CH_O) || (c == CH_U);
  endfunction

endpackage

// File: rtl/pwd_shift_reg.sv
// Parallel-load shift register holding the password; the character to
// send next always sits in the lowest CHAR_W bits.
module pwd_shift_reg #(
  parameter int MAX_LEN = 16,
  parameter int CHAR_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic [MAX_LEN*CHAR_W-1:0]   data_i,
  input  logic                        shift_i,
  output logic [CHAR_W-1:0]           low_o
);

  logic [MAX_LEN*CHAR_W-1:0] data_q;

  // Load wins over shift; shifting moves the next character into the low slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= {{CHAR_W{1'b0}}, data_q[MAX_LEN*CHAR_W-1:CHAR_W]};
    end
  end

  assign low_o = data_q[CHAR_W-1:0];

endmodule

// File: rtl/password_char_tx.sv
// Transmit-side serializer: captures a packed password on load and emits
// it one character per valid/ready transfer, flagging the last character
// and pulsing done once the final transfer has completed.
module password_char_tx
  import pwd_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CHAR_W  = DEF_CHAR_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [MAX_LEN*CHAR_W-1:0]   pwd_in,
  input  logic [LEN_W-1:0]            len_in,
  input  logic                        abort,
  output logic [CHAR_W-1:0]           char_out,
  output logic                        char_valid,
  input  logic                        char_ready,
  output logic                        char_last,
  output logic                        busy,
  output logic                        done,
  output logic                        err_len
);

  tx_state_e         state_q;
  logic [LEN_W-1:0]  rem_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              len_ok;
  logic              capture;
  logic              xfer;
  logic              shift;
  logic [CHAR_W-1:0] low_char;

  // Request decode: legal length, capture enable, handshake transfer.
  // abort suppresses the shift so a cancelled transfer never advances data.
  always_comb begin
    len_ok  = (len_in != '0) && (int'(len_in) <= MAX_LEN);
    capture = (state_q == IDLE) && load && len_ok;
    xfer    = (state_q == SEND) && valid_q && char_ready;
    shift   = xfer && !abort;
  end

  pwd_shift_reg #(
    .MAX_LEN (MAX_LEN),
    .CHAR_W  (CHAR_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_i  (capture),
    .data_i  (pwd_in),
    .shift_i (shift),
    .low_o   (low_char)
  );

  // Tx FSM with registered handshake/status outputs; char_last tracks
  // remaining==1 one cycle ahead so it is ready alongside each character.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            if (len_ok) begin
              state_q <= SEND;
              rem_q   <= len_in;
              valid_q <= 1'b1;
              last_q  <= (len_in == LEN_W'(1));
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (abort) begin
            state_q <= IDLE;
            rem_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (xfer) begin
            if (last_q) begin
              state_q <= DONE;
              rem_q   <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              rem_q  <= rem_q - LEN_W'(1);
              last_q <= (rem_q == LEN_W'(2));
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          rem_q   <= '0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Character bus reads as zero whenever no character is offered.
  assign char_out   = valid_q ? low_char : '0;
  assign char_valid = valid_q;
  assign char_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_len    = err_q;

endmodule

// File: tb/tb_password_char_tx.sv
// Scoreboard bench for password_char_tx: stimulus pushes expected
// characters, a negedge monitor pops and compares on every transfer.
module tb_password_char_tx;
  import pwd_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int CHAR_W  = 8;
  localparam int LEN_W   = 5;

  logic                      clk;
  logic                      rst;
  logic                      load;
  logic [MAX_LEN*CHAR_W-1:0] pwd_in;
  logic [LEN_W-1:0]          len_in;
  logic                      abort;
  logic [CHAR_W-1:0]         char_out;
  logic                      char_valid;
  logic                      char_ready;
  logic                      char_last;
  logic                      busy;
  logic                      done;
  logic                      err_len;

  password_char_tx #(
    .MAX_LEN (MAX_LEN),
    .CHAR_W  (CHAR_W),
    .LEN_W   (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .pwd_in     (pwd_in),
    .len_in     (len_in),
    .abort      (abort),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_last  (char_last),
    .busy       (busy),
    .done       (done),
    .err_len    (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] c;
    logic       l;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_bad = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int vowel_cnt = 0;
  logic [7:0] last_flag_char = 8'h00;

  logic       pv = 1'b0;
  logic [9:0] pvd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [MAX_LEN*CHAR_W-1:0] pack(input string s);
    logic [MAX_LEN*CHAR_W-1:0] p;
    p = '0;
    for (int k = 0; k < s.len(); k++) p[k*CHAR_W +: CHAR_W] = s[k];
    return p;
  endfunction

  // Monitor: counts events, checks idle-zero and hold, pops scoreboard on transfers.
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (err_len) err_cnt++;
      if (!char_valid) chk("idle_char_zero", 32'(char_out), 32'd0);
      if (pv) chk("hold_stable", 32'({char_valid, char_out, char_last}), 32'(pvd));
      if (char_valid && char_ready && !abort) begin
        xfer_cnt++;
        if (is_vowel(char_out)) vowel_cnt++;
        if (char_last) last_flag_char = char_out;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got char %0h with nothing expected (t=%0t)", char_out, $time);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_char", 32'(char_out), 32'(mon_e.c));
          chk("sb_last", 32'(char_last), 32'(mon_e.l));
        end
      end
      pv  = char_valid && !char_ready && !abort;
      pvd = {1'b1, char_out, char_last};
    end
  end

  task automatic do_load(input string s, input int len, input bit expect_ok);
    exp_t e;
    @(posedge clk); #1;
    pwd_in = pack(s);
    len_in = LEN_W'(len);
    load   = 1'b1;
    if (expect_ok) begin
      for (int k = 0; k < len; k++) begin
        e.c = s[k];
        e.l = (k == len - 1);
        sb_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    for (int k = 0; k < maxc; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string s;
    int b_x, b_d, b_e, b_v;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; load = 1'b0; abort = 1'b0; char_ready = 1'b0;
    pwd_in = '0; len_in = '0;
    #12;
    chk("rst_char_out", 32'(char_out), 32'd0);
    chk("rst_valid", 32'(char_valid), 32'd0);
    chk("rst_last", 32'(char_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_len), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // aeiou with constant ready: one char per cycle, latency 1
    b_x = xfer_cnt; b_d = done_cnt;
    s = "aeiou";
    char_ready = 1'b1;
    do_load(s, 5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("aeiou_valid", 32'(char_valid), 32'd1);
      chk("aeiou_char", 32'(char_out), 32'(s[k]));
      chk("aeiou_last", 32'(char_last), 32'(k == 4));
    end
    @(negedge clk);
    chk("aeiou_done", 32'(done), 32'd1);
    chk("aeiou_valid_drop", 32'(char_valid), 32'd0);
    chk("aeiou_busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("aeiou_done_pulse", 32'(done), 32'd0);
    chk("aeiou_busy_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("aeiou_xfers", 32'(xfer_cnt - b_x), 32'd5);
    chk("aeiou_done_cnt", 32'(done_cnt - b_d), 32'd1);
    chk("aeiou_sb_empty", 32'(sb_q.size()), 32'd0);

    // pass with ready toggling 1,0,0,1
    b_x = xfer_cnt; b_d = done_cnt;
    char_ready = 1'b1;
    do_load("pass", 4, 1'b1);
    for (int i = 0; i < 60; i++) begin
      char_ready = pat[i % 4];
      @(posedge clk); #1;
      if (!busy) break;
    end
    chk("pass_timeout", 32'(busy), 32'd0);
    chk("pass_xfers", 32'(xfer_cnt - b_x), 32'd4);
    chk("pass_done_cnt", 32'(done_cnt - b_d), 32'd1);
    chk("pass_sb_empty", 32'(sb_q.size()), 32'd0);

    // illegal lengths 0 and 17
    b_x = xfer_cnt; b_d = done_cnt; b_e = err_cnt;
    char_ready = 1'b1;
    do_load("", 0, 1'b0);
    chk("len0_err", 32'(err_len), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_valid", 32'(char_valid), 32'd0);
    @(posedge clk); #1;
    chk("len0_err_pulse", 32'(err_len), 32'd0);
    do_load("abcdefghijklmnopq", 17, 1'b0);
    chk("len17_err", 32'(err_len), 32'd1);
    chk("len17_busy", 32'(busy), 32'd0);
    chk("len17_valid", 32'(char_valid), 32'd0);
    @(posedge clk); #1;
    chk("len17_err_pulse", 32'(err_len), 32'd0);
    @(posedge clk); #1;
    chk("badlen_err_cnt", 32'(err_cnt - b_e), 32'd2);
    chk("badlen_xfers", 32'(xfer_cnt - b_x), 32'd0);
    chk("badlen_done_cnt", 32'(done_cnt - b_d), 32'd0);

    // abort after first transfer, then a clean xy stream
    b_x = xfer_cnt; b_d = done_cnt;
    char_ready = 1'b1;
    do_load("abc", 3, 1'b1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", 32'(char_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_char", 32'(char_out), 32'd0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - b_d), 32'd0);
    chk("abort_xfers", 32'(xfer_cnt - b_x), 32'd1);
    b_x = xfer_cnt; b_d = done_cnt;
    do_load("xy", 2, 1'b1);
    wait_idle(20, "xy_timeout");
    chk("xy_xfers", 32'(xfer_cnt - b_x), 32'd2);
    chk("xy_done_cnt", 32'(done_cnt - b_d), 32'd1);
    chk("xy_sb_empty", 32'(sb_q.size()), 32'd0);

    // 16-char stream: ignored load while busy, then async reset mid-stream
    b_x = xfer_cnt; b_d = done_cnt; b_e = err_cnt;
    char_ready = 1'b1;
    do_load("0123456789ABCDEF", 16, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    do_load("ZZZZ", 4, 1'b0);
    chk("busyload_err", 32'(err_len), 32'd0);
    chk("busyload_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_char_out", 32'(char_out), 32'd0);
    chk("mrst_valid", 32'(char_valid), 32'd0);
    chk("mrst_last", 32'(char_last), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_err", 32'(err_len), 32'd0);
    #4;
    rst = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    chk("mrst_xfers", 32'(xfer_cnt - b_x), 32'd5);
    chk("mrst_no_done", 32'(done_cnt - b_d), 32'd0);
    chk("mrst_no_err", 32'(err_cnt - b_e), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);

    // bread through the vowel checker
    b_x = xfer_cnt; b_d = done_cnt; b_v = vowel_cnt;
    char_ready = 1'b1;
    do_load("bread", 5, 1'b1);
    wait_idle(20, "bread_timeout");
    chk("bread_vowels", 32'(vowel_cnt - b_v), 32'd2);
    chk("bread_last_char", 32'(last_flag_char), 32'h64);
    chk("bread_xfers", 32'(xfer_cnt - b_x), 32'd5);
    chk("bread_done_cnt", 32'(done_cnt - b_d), 32'd1);
    chk("bread_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
